// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch stage
// Owns the PC and runs one memory read per accepted fetch request.
module pc_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              en_ram_in,
  input  logic              en_pc_pulse,
  input  logic [1:0]        pc_ctrl,
  input  logic [7:0]        offset_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ins,
  output logic              en_ram_out,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CAP} state_t;

  localparam logic [3:0]        LAT_LAST = 4'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [3:0]        lat_cnt;
  logic              accept, capture;
  logic [ADDR_W-1:0] off_sext, off_zext, pc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (en_ram_in && en) begin
          accept    = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          capture   = 1'b1;
          state_nxt = S_CAP;
        end
      end
      S_CAP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Offset is an 8-bit IR field; widen it to the PC width.
  always_comb begin
    off_sext      = {ADDR_W{offset_addr[7]}};
    off_sext[7:0] = offset_addr;
    off_zext      = '0;
    off_zext[7:0] = offset_addr;
  end

  always_comb begin
    pc_nxt = pc;
    case (pc_ctrl)
      2'b01:   pc_nxt = pc + PC_ONE;
      2'b10:   pc_nxt = pc + off_sext;
      2'b11:   pc_nxt = off_zext;
      default: pc_nxt = pc;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd     <= 1'b0;
      en_ram_out <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= PC_RST;
      lat_cnt    <= 4'd0;
      ins        <= '0;
      pc         <= PC_RST;
    end else begin
      mem_rd     <= (state_nxt == S_REQ);
      en_ram_out <= (state_nxt == S_CAP);
      busy       <= (state_nxt != S_IDLE);
      if (accept)
        mem_addr <= pc;
      if (state == S_REQ)
        lat_cnt <= 4'd0;
      else if (state == S_WAIT)
        lat_cnt <= lat_cnt + 4'd1;
      if (capture)
        ins <= mem_data;
      if (en_pc_pulse && en)
        pc <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
// Two instances (RD_LAT=1 and RD_LAT=3) share stimulus; each has its own memory port.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, en, en_ram_in, en_pc_pulse;
  logic [1:0]  pc_ctrl;
  logic [7:0]  offset_addr;

  logic [7:0]  mem_addr1, mem_addr3, pc1, pc3;
  logic        mem_rd1, mem_rd3, ero1, ero3, busy1, busy3;
  logic [15:0] mem_data1, mem_data3, ins1, ins3;

  logic [15:0] mem [256];
  assign mem_data1 = mem[mem_addr1];
  assign mem_data3 = mem[mem_addr3];

  pc_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .RESET_PC(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .en_ram_in(en_ram_in), .en_pc_pulse(en_pc_pulse),
    .pc_ctrl(pc_ctrl), .offset_addr(offset_addr), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .mem_data(mem_data1), .ins(ins1), .en_ram_out(ero1), .busy(busy1), .pc(pc1));

  pc_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .RESET_PC(0)) u3 (
    .clk(clk), .rst(rst), .en(en), .en_ram_in(en_ram_in), .en_pc_pulse(en_pc_pulse),
    .pc_ctrl(pc_ctrl), .offset_addr(offset_addr), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
    .mem_data(mem_data3), .ins(ins3), .en_ram_out(ero3), .busy(busy3), .pc(pc3));

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          nrd1, nrd3;
  logic [15:0] exp1[$], exp3[$], got1[$], got3[$];
  int          gt1[$], gt3[$];
  logic [7:0]  pc_m;

  // Advance one cycle and record what each DUT produced in it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ero1) begin got1.push_back(ins1); gt1.push_back(cyc); end
    if (ero3) begin got3.push_back(ins3); gt3.push_back(cyc); end
    if (mem_rd1) nrd1++;
    if (mem_rd3) nrd3++;
  endtask

  task automatic clear_obs();
    got1.delete(); got3.delete(); gt1.delete(); gt3.delete();
    nrd1 = 0; nrd3 = 0;
  endtask

  task automatic set_pc(input logic [7:0] v);
    en_pc_pulse = 1'b1; pc_ctrl = 2'b11; offset_addr = v;
    tick();
    en_pc_pulse = 1'b0; pc_ctrl = 2'b00;
    pc_m = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; en_ram_in = 1'b0; en_pc_pulse = 1'b0;
    pc_ctrl = 2'b00; offset_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({pc1, mem_addr1, mem_rd1, ins1, ero1, busy1} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_u1: pc=%h addr=%h rd=%b ins=%h out=%b busy=%b, want all zero",
               pc1, mem_addr1, mem_rd1, ins1, ero1, busy1);
    end
    n_checks++;
    if ({pc3, mem_addr3, mem_rd3, ins3, ero3, busy3} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_u3: pc=%h addr=%h rd=%b ins=%h out=%b busy=%b, want all zero",
               pc3, mem_addr3, mem_rd3, ins3, ero3, busy3);
    end
    rst = 1'b0;
    pc_m = 8'h00;
    tick();
  endtask

  task automatic test_basic_fetch();
    int c0;
    logic [15:0] e;
    clear_obs();
    c0 = cyc;
    en_ram_in = 1'b1;
    exp1.push_back(mem[pc_m]); exp3.push_back(mem[pc_m]);
    tick();
    en_ram_in = 1'b0;
    n_checks++;
    if ({mem_rd1, mem_addr1, busy1, ero1} !== {1'b1, pc_m, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_req: rd=%b addr=%h busy=%b out=%b, want rd=1 addr=%h busy=1 out=0",
               mem_rd1, mem_addr1, busy1, ero1, pc_m);
    end
    tick();
    n_checks++;
    if ({mem_rd1, ero1, busy1} !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_wait: rd=%b out=%b busy=%b, want 0 0 1", mem_rd1, ero1, busy1);
    end
    tick();
    n_checks++;
    if ({ero1, busy1, ins1} !== {2'b11, 16'hA123}) begin
      n_fail++;
      $display("FAIL basic_cap: out=%b busy=%b ins=%h, want 1 1 a123", ero1, busy1, ins1);
    end
    tick();
    n_checks++;
    if ({ero1, busy1, ins1} !== {2'b00, 16'hA123}) begin
      n_fail++;
      $display("FAIL basic_idle: out=%b busy=%b ins=%h, want 0 0 a123", ero1, busy1, ins1);
    end
    repeat (4) tick();
    n_checks++;
    if (got1.size() != 1 || nrd1 != 1) begin
      n_fail++;
      $display("FAIL basic_sb_u1: strobes=%0d reads=%0d, want 1 1", got1.size(), nrd1);
    end else begin
      e = exp1.pop_front();
      n_checks++;
      if (gt1[0] - c0 != 3 || got1[0] !== e) begin
        n_fail++;
        $display("FAIL basic_u1: lat=%0d ins=%h, want lat=3 ins=%h", gt1[0] - c0, got1[0], e);
      end
    end
    n_checks++;
    if (got3.size() != 1 || nrd3 != 1) begin
      n_fail++;
      $display("FAIL basic_sb_u3: strobes=%0d reads=%0d, want 1 1", got3.size(), nrd3);
    end else begin
      e = exp3.pop_front();
      n_checks++;
      if (gt3[0] - c0 != 5 || got3[0] !== e) begin
        n_fail++;
        $display("FAIL basic_u3: lat=%0d ins=%h, want lat=5 ins=%h", gt3[0] - c0, got3[0], e);
      end
    end
  endtask

  task automatic test_pc_update();
    logic [1:0] ctl [7] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01};
    logic [7:0] off [7] = '{8'h10, 8'h00, 8'hFE, 8'h40, 8'h55, 8'hFF, 8'h00};
    logic [7:0] want[7] = '{8'h10, 8'h11, 8'h0F, 8'h40, 8'h40, 8'hFF, 8'h00};
    for (int i = 0; i < 7; i++) begin
      en_pc_pulse = 1'b1; pc_ctrl = ctl[i]; offset_addr = off[i];
      tick();
      en_pc_pulse = 1'b0;
      n_checks++;
      if (pc1 !== want[i] || pc3 !== want[i]) begin
        n_fail++;
        $display("FAIL pc_update_%0d: pc=%h/%h, want %h", i, pc1, pc3, want[i]);
      end
    end
    pc_ctrl = 2'b00;
    pc_m = 8'h00;
  endtask

  task automatic test_simultaneous();
    int c0;
    logic [15:0] e;
    set_pc(8'h05);
    clear_obs();
    c0 = cyc;
    en_ram_in = 1'b1; en_pc_pulse = 1'b1; pc_ctrl = 2'b01;
    exp1.push_back(mem[pc_m]); exp3.push_back(mem[pc_m]);
    tick();
    en_ram_in = 1'b0; en_pc_pulse = 1'b0;
    n_checks++;
    if ({mem_addr1, mem_addr3, pc1} !== {8'h05, 8'h05, 8'h06}) begin
      n_fail++;
      $display("FAIL simul_latch: addr=%h/%h pc=%h, want 05/05 pc=06", mem_addr1, mem_addr3, pc1);
    end
    tick();
    en_pc_pulse = 1'b1; pc_ctrl = 2'b01;
    tick();
    en_pc_pulse = 1'b0;
    n_checks++;
    if ({mem_addr1, mem_addr3, pc1, pc3} !== {8'h05, 8'h05, 8'h07, 8'h07}) begin
      n_fail++;
      $display("FAIL simul_wait: addr=%h/%h pc=%h/%h, want 05/05 pc=07", mem_addr1, mem_addr3, pc1, pc3);
    end
    pc_m = 8'h07;
    repeat (6) tick();
    n_checks++;
    if (got1.size() != 1 || got3.size() != 1) begin
      n_fail++;
      $display("FAIL simul_sb: strobes=%0d/%0d, want 1/1", got1.size(), got3.size());
    end else begin
      e = exp1.pop_front();
      n_checks++;
      if (got1[0] !== e || got1[0] !== 16'hC0DE) begin
        n_fail++;
        $display("FAIL simul_u1: ins=%h, want %h", got1[0], e);
      end
      e = exp3.pop_front();
      n_checks++;
      if (gt3[0] - c0 != 5 || got3[0] !== e) begin
        n_fail++;
        $display("FAIL simul_u3: lat=%0d ins=%h, want lat=5 ins=%h", gt3[0] - c0, got3[0], e);
      end
    end
  endtask

  task automatic test_drop_busy();
    int c0;
    logic [15:0] e;
    clear_obs();
    c0 = cyc;
    en_ram_in = 1'b1;
    exp1.push_back(mem[pc_m]); exp3.push_back(mem[pc_m]);
    // Held high through REQ/WAIT and the RD_LAT=1 CAP cycle: all dropped.
    repeat (4) tick();
    en_ram_in = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (nrd1 != 1 || nrd3 != 1 || got1.size() != 1 || got3.size() != 1) begin
      n_fail++;
      $display("FAIL drop_counts: reads=%0d/%0d strobes=%0d/%0d, want 1/1 1/1",
               nrd1, nrd3, got1.size(), got3.size());
    end else begin
      e = exp1.pop_front();
      n_checks++;
      if (gt1[0] - c0 != 3 || got1[0] !== e) begin
        n_fail++;
        $display("FAIL drop_u1: lat=%0d ins=%h, want lat=3 ins=%h", gt1[0] - c0, got1[0], e);
      end
      e = exp3.pop_front();
      n_checks++;
      if (gt3[0] - c0 != 5 || got3[0] !== e) begin
        n_fail++;
        $display("FAIL drop_u3: lat=%0d ins=%h, want lat=5 ins=%h", gt3[0] - c0, got3[0], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    set_pc(8'h30);
    clear_obs();
    en_ram_in = 1'b1;
    exp1.push_back(mem[pc_m]); exp3.push_back(mem[pc_m]);
    tick();
    en_ram_in = 1'b0;
    set_pc(8'h31);
    repeat (2) tick();
    // u1 is idle again here; u3 is still waiting, so only u1 takes this one.
    en_ram_in = 1'b1;
    exp1.push_back(mem[pc_m]);
    tick();
    en_ram_in = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (nrd1 != 2 || got1.size() != 2 || nrd3 != 1 || got3.size() != 1) begin
      n_fail++;
      $display("FAIL b2b_counts: u1 reads=%0d strobes=%0d, u3 reads=%0d strobes=%0d, want 2 2 1 1",
               nrd1, got1.size(), nrd3, got3.size());
    end else begin
      n_checks++;
      if (gt1[1] - gt1[0] != 4) begin
        n_fail++;
        $display("FAIL b2b_spacing: %0d cycles, want 4", gt1[1] - gt1[0]);
      end
      for (int i = 0; i < 2; i++) begin
        e = exp1.pop_front();
        n_checks++;
        if (got1[i] !== e) begin
          n_fail++;
          $display("FAIL b2b_u1_%0d: ins=%h, want %h", i, got1[i], e);
        end
      end
      e = exp3.pop_front();
      n_checks++;
      if (got3[0] !== e) begin
        n_fail++;
        $display("FAIL b2b_u3: ins=%h, want %h", got3[0], e);
      end
    end
  endtask

  task automatic test_enable();
    int c0;
    logic [15:0] e;
    clear_obs();
    en = 1'b0; en_ram_in = 1'b1; en_pc_pulse = 1'b1; pc_ctrl = 2'b01;
    repeat (2) tick();
    en_ram_in = 1'b0; en_pc_pulse = 1'b0;
    tick();
    n_checks++;
    if (nrd1 != 0 || nrd3 != 0 || busy1 || busy3 || pc1 !== pc_m || pc3 !== pc_m) begin
      n_fail++;
      $display("FAIL en_low: reads=%0d/%0d busy=%b/%b pc=%h/%h, want 0/0 0/0 pc=%h",
               nrd1, nrd3, busy1, busy3, pc1, pc3, pc_m);
    end
    en = 1'b1;
    c0 = cyc;
    en_ram_in = 1'b1;
    exp1.push_back(mem[pc_m]); exp3.push_back(mem[pc_m]);
    tick();
    en_ram_in = 1'b0; en = 1'b0;
    repeat (7) tick();
    en = 1'b1;
    n_checks++;
    if (got1.size() != 1 || got3.size() != 1) begin
      n_fail++;
      $display("FAIL en_drop_sb: strobes=%0d/%0d, want 1/1", got1.size(), got3.size());
    end else begin
      e = exp3.pop_front();
      n_checks++;
      if (gt3[0] - c0 != 5 || got3[0] !== e) begin
        n_fail++;
        $display("FAIL en_drop_u3: lat=%0d ins=%h, want lat=5 ins=%h", gt3[0] - c0, got3[0], e);
      end
      e = exp1.pop_front();
      n_checks++;
      if (got1[0] !== e) begin
        n_fail++;
        $display("FAIL en_drop_u1: ins=%h, want %h", got1[0], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    set_pc(8'h20);
    clear_obs();
    en_ram_in = 1'b1;
    tick();
    en_ram_in = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({pc1, mem_addr1, mem_rd1, ins1, ero1, busy1, pc3, mem_addr3, mem_rd3, ins3, ero3, busy3} !== 70'h0) begin
      n_fail++;
      $display("FAIL rst_mid: u1 pc=%h addr=%h ins=%h busy=%b u3 pc=%h addr=%h ins=%h busy=%b, want all zero",
               pc1, mem_addr1, ins1, busy1, pc3, mem_addr3, ins3, busy3);
    end
    repeat (2) tick();
    rst = 1'b0;
    pc_m = 8'h00;
    clear_obs();
    repeat (6) tick();
    n_checks++;
    if (got1.size() != 0 || got3.size() != 0 || nrd1 != 0 || nrd3 != 0) begin
      n_fail++;
      $display("FAIL rst_abort: strobes=%0d/%0d reads=%0d/%0d, want none",
               got1.size(), got3.size(), nrd1, nrd3);
    end
    en_ram_in = 1'b1;
    exp1.push_back(mem[pc_m]); exp3.push_back(mem[pc_m]);
    tick();
    en_ram_in = 1'b0;
    n_checks++;
    if ({mem_rd1, mem_addr1, mem_rd3, mem_addr3} !== {1'b1, 8'h00, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_refetch_addr: rd=%b/%b addr=%h/%h, want 1/1 00/00",
               mem_rd1, mem_rd3, mem_addr1, mem_addr3);
    end
    repeat (7) tick();
    n_checks++;
    if (got1.size() != 1 || got3.size() != 1) begin
      n_fail++;
      $display("FAIL rst_refetch_sb: strobes=%0d/%0d, want 1/1", got1.size(), got3.size());
    end else begin
      e = exp1.pop_front();
      n_checks++;
      if (got1[0] !== e || got1[0] !== 16'hA123) begin
        n_fail++;
        $display("FAIL rst_refetch_u1: ins=%h, want %h", got1[0], e);
      end
      e = exp3.pop_front();
      n_checks++;
      if (got3[0] !== e) begin
        n_fail++;
        $display("FAIL rst_refetch_u3: ins=%h, want %h", got3[0], e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 263) ^ 16'h3C5A;
    mem[0] = 16'hA123;
    mem[5] = 16'hC0DE;
    test_reset();
    test_basic_fetch();
    test_pc_update();
    test_simultaneous();
    test_drop_busy();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
